// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches car and hall calls, sweeps in one
// direction while calls remain ahead, and supports door hold and a toggling emergency stop.
module elevator_scan_ctrl #(
  parameter int N_FLOORS      = 8,
  parameter int CLK_HZ        = 10_000,
  parameter int SEC_PER_FLOOR = 1,
  parameter int DOOR_OPEN_SEC = 1
) (
  input  logic                        i_clk,
  input  logic                        i_rst_n,
  input  logic [N_FLOORS-1:0]         i_hall_up,
  input  logic [N_FLOORS-1:0]         i_hall_dn,
  input  logic [N_FLOORS-1:0]         i_car_req,
  input  logic                        i_stop,
  input  logic                        i_door_hold,
  output logic [$clog2(N_FLOORS)-1:0] o_current_floor,
  output logic                        o_up,
  output logic                        o_down,
  output logic                        o_door,
  output logic [N_FLOORS-1:0]         o_pending,
  output logic                        o_halted
);
  localparam int FW          = $clog2(N_FLOORS);
  localparam int FLOOR_TICKS = CLK_HZ * SEC_PER_FLOOR;
  localparam int DOOR_TICKS  = CLK_HZ * DOOR_OPEN_SEC;
  localparam int TW          = $clog2(FLOOR_TICKS + 1);
  localparam int DW          = $clog2(DOOR_TICKS + 1);
  localparam logic [TW-1:0] TRAVEL_LAST = TW'(FLOOR_TICKS - 1);
  localparam logic [DW-1:0] DOOR_LOAD   = DW'(DOOR_TICKS - 1);
  localparam logic [N_FLOORS-1:0] UP_MASK = {1'b0, {(N_FLOORS-1){1'b1}}};
  localparam logic [N_FLOORS-1:0] DN_MASK = {{(N_FLOORS-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {S_IDLE, S_MOVE_UP, S_MOVE_DN, S_DOOR_OPEN, S_HALT} state_t;
  typedef enum logic [1:0] {D_NONE, D_UP, D_DN} dir_t;

  state_t state, saved_state, nxt_state;
  dir_t   dir, nxt_dir;
  logic [FW-1:0]       floor, nxt_floor, tf;
  logic [TW-1:0]       travel_cnt, nxt_travel;
  logic [DW-1:0]       door_cnt, nxt_door;
  logic [N_FLOORS-1:0] car_q, up_q, dn_q, any_q;
  logic [N_FLOORS-1:0] new_car, new_up, new_dn, new_any;
  logic [N_FLOORS-1:0] onehot, le_mask, above, below;
  logic [N_FLOORS-1:0] block, clr_car, clr_up, clr_dn;
  logic motor_up, motor_dn, door_open, halted;
  logic arrive, here, beyond_up, beyond_dn, new_here;
  logic dir_hall, none_beyond, stop_here, serve;

  // All floor tests are made against tf: the floor being arrived at on a terminal
  // travel count, otherwise the floor the car is standing at.
  always_comb begin
    new_car = i_car_req;
    new_up  = i_hall_up & UP_MASK;
    new_dn  = i_hall_dn & DN_MASK;
    new_any = new_car | new_up | new_dn;
    any_q   = car_q | up_q | dn_q;
    arrive  = ((state == S_MOVE_UP) || (state == S_MOVE_DN)) && (travel_cnt == TRAVEL_LAST);
    tf = floor;
    if (arrive) tf = (state == S_MOVE_UP) ? floor + 1'b1 : floor - 1'b1;
    onehot    = N_FLOORS'(1) << tf;
    le_mask   = (onehot << 1) - N_FLOORS'(1);
    above     = ~le_mask;
    below     = le_mask & ~onehot;
    here      = |(any_q & onehot);
    beyond_up = |(any_q & above);
    beyond_dn = |(any_q & below);
    new_here  = |(new_any & onehot);

    dir_hall    = 1'b0;
    none_beyond = 1'b0;
    case (dir)
      D_UP: begin
        dir_hall    = |(up_q & onehot);
        none_beyond = !beyond_up;
      end
      D_DN: begin
        dir_hall    = |(dn_q & onehot);
        none_beyond = !beyond_dn;
      end
      default: dir_hall = |((up_q | dn_q) & onehot);
    endcase
    stop_here = (|(car_q & onehot)) | dir_hall | none_beyond;

    nxt_state  = state;
    nxt_dir    = dir;
    nxt_floor  = floor;
    nxt_travel = travel_cnt;
    nxt_door   = door_cnt;
    block      = '0;
    clr_car    = '0;
    clr_up     = '0;
    clr_dn     = '0;
    serve      = 1'b0;

    case (state)
      S_IDLE: begin
        if (here && stop_here) begin
          serve = 1'b1;
        end else if ((dir != D_DN) && beyond_up) begin
          nxt_state  = S_MOVE_UP;
          nxt_dir    = D_UP;
          nxt_travel = '0;
        end else if (beyond_dn) begin
          nxt_state  = S_MOVE_DN;
          nxt_dir    = D_DN;
          nxt_travel = '0;
        end else if (beyond_up) begin
          nxt_state  = S_MOVE_UP;
          nxt_dir    = D_UP;
          nxt_travel = '0;
        end else begin
          nxt_dir = D_NONE;
        end
      end
      S_MOVE_UP, S_MOVE_DN: begin
        if (arrive) begin
          nxt_floor  = tf;
          nxt_travel = '0;
          serve      = stop_here;
        end else begin
          nxt_travel = travel_cnt + 1'b1;
        end
      end
      S_DOOR_OPEN: begin
        block = onehot;
        if (i_door_hold || new_here) nxt_door = DOOR_LOAD;
        else if (door_cnt == '0)     nxt_state = S_IDLE;
        else                         nxt_door = door_cnt - 1'b1;
      end
      default: ;
    endcase

    // With nothing left ahead the car turns around, so the opposite hall call is answered too.
    if (serve) begin
      nxt_state = S_DOOR_OPEN;
      nxt_door  = DOOR_LOAD;
      clr_car   = onehot;
      if (none_beyond || (dir != D_DN)) clr_up = onehot;
      if (none_beyond || (dir != D_UP)) clr_dn = onehot;
      if (none_beyond) nxt_dir = (dir == D_UP) ? D_DN : D_UP;
    end
  end

  // Stop freezes the already-advanced next state; the following stop replays it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state       <= S_IDLE;
      saved_state <= S_IDLE;
      dir         <= D_NONE;
      floor       <= '0;
      travel_cnt  <= '0;
      door_cnt    <= '0;
      car_q       <= '0;
      up_q        <= '0;
      dn_q        <= '0;
      motor_up    <= 1'b0;
      motor_dn    <= 1'b0;
      door_open   <= 1'b0;
      halted      <= 1'b0;
    end else begin
      car_q <= (car_q | (new_car & ~block)) & ~clr_car;
      up_q  <= (up_q  | (new_up  & ~block)) & ~clr_up;
      dn_q  <= (dn_q  | (new_dn  & ~block)) & ~clr_dn;
      if (state == S_HALT) begin
        if (i_stop) begin
          state     <= saved_state;
          halted    <= 1'b0;
          motor_up  <= (saved_state == S_MOVE_UP);
          motor_dn  <= (saved_state == S_MOVE_DN);
          door_open <= (saved_state == S_DOOR_OPEN);
        end
      end else begin
        floor      <= nxt_floor;
        dir        <= nxt_dir;
        travel_cnt <= nxt_travel;
        door_cnt   <= nxt_door;
        if (i_stop) begin
          state       <= S_HALT;
          saved_state <= nxt_state;
          halted      <= 1'b1;
          motor_up    <= 1'b0;
          motor_dn    <= 1'b0;
        end else begin
          state     <= nxt_state;
          motor_up  <= (nxt_state == S_MOVE_UP);
          motor_dn  <= (nxt_state == S_MOVE_DN);
          door_open <= (nxt_state == S_DOOR_OPEN);
        end
      end
    end
  end

  assign o_current_floor = floor;
  assign o_up            = motor_up;
  assign o_down          = motor_dn;
  assign o_door          = door_open;
  assign o_pending       = any_q;
  assign o_halted        = halted;
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Bench for elevator_scan_ctrl: directed scenarios plus random calls, all compared each
// cycle against a floor-by-floor behavioural model of the SCAN rules.
module tb_elevator_scan_ctrl;
  localparam int N  = 8;
  localparam int FT = 10;
  localparam int DT = 10;

  logic         i_clk = 1'b0;
  logic         i_rst_n = 1'b0;
  logic [N-1:0] i_hall_up = '0, i_hall_dn = '0, i_car_req = '0;
  logic         i_stop = 1'b0, i_door_hold = 1'b0;
  logic [2:0]   o_current_floor;
  logic         o_up, o_down, o_door, o_halted;
  logic [N-1:0] o_pending;

  int checks = 0;
  int errors = 0;
  int door_floors[$];
  logic prev_door = 1'b0;

  // Model state: mode 0 idle, 1 travelling, 2 door open; dir -1/0/+1.
  bit m_car[N], m_up[N], m_dn[N];
  int m_floor, m_dir, m_mode, m_elapsed, m_door_left;
  bit m_halted, m_door_frozen;

  always #5 i_clk = ~i_clk;

  elevator_scan_ctrl #(
    .N_FLOORS(N), .CLK_HZ(10), .SEC_PER_FLOOR(1), .DOOR_OPEN_SEC(1)
  ) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_hall_up(i_hall_up), .i_hall_dn(i_hall_dn),
    .i_car_req(i_car_req), .i_stop(i_stop), .i_door_hold(i_door_hold),
    .o_current_floor(o_current_floor), .o_up(o_up), .o_down(o_down), .o_door(o_door),
    .o_pending(o_pending), .o_halted(o_halted)
  );

  function automatic bit m_beyond(int f, int d);
    for (int i = 0; i < N; i++)
      if (((d > 0) && (i > f)) || ((d < 0) && (i < f)))
        if (m_car[i] || m_up[i] || m_dn[i]) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit m_hall(int f, int d);
    if (d > 0) return m_up[f];
    if (d < 0) return m_dn[f];
    return m_up[f] | m_dn[f];
  endfunction

  function automatic bit m_door_out();
    return m_halted ? m_door_frozen : (m_mode == 2);
  endfunction

  function automatic logic [N-1:0] m_pending();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = m_car[i] | m_up[i] | m_dn[i];
    return p;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_car[i] = 0; m_up[i] = 0; m_dn[i] = 0;
    end
    m_floor = 0; m_dir = 0; m_mode = 0; m_elapsed = 0; m_door_left = 0;
    m_halted = 0; m_door_frozen = 0;
  endtask

  task automatic model_tick();
    bit n_car[N], n_up[N], n_dn[N];
    bit door_before, do_serve, do_flip, suppress;
    int f;
    door_before = m_door_out();
    for (int i = 0; i < N; i++) begin
      n_car[i] = i_car_req[i];
      n_up[i]  = (i < N - 1) && i_hall_up[i];
      n_dn[i]  = (i > 0) && i_hall_dn[i];
    end
    if (m_halted) begin
      for (int i = 0; i < N; i++) begin
        m_car[i] |= n_car[i]; m_up[i] |= n_up[i]; m_dn[i] |= n_dn[i];
      end
      if (i_stop) m_halted = 0;
      return;
    end
    do_serve = 0; do_flip = 0; suppress = 0;
    f = m_floor;
    if (m_mode == 0) begin
      if ((m_car[f] || m_up[f] || m_dn[f]) &&
          (m_car[f] || m_hall(f, m_dir) || (m_dir != 0 && !m_beyond(f, m_dir)))) begin
        do_serve = 1;
        do_flip  = (m_dir != 0) && !m_beyond(f, m_dir);
      end else if (m_dir >= 0 && m_beyond(f, 1)) begin
        m_mode = 1; m_dir = 1; m_elapsed = 0;
      end else if (m_beyond(f, -1)) begin
        m_mode = 1; m_dir = -1; m_elapsed = 0;
      end else if (m_beyond(f, 1)) begin
        m_mode = 1; m_dir = 1; m_elapsed = 0;
      end else begin
        m_dir = 0;
      end
    end else if (m_mode == 1) begin
      m_elapsed++;
      if (m_elapsed == FT) begin
        m_elapsed = 0;
        m_floor += m_dir;
        f = m_floor;
        if (m_car[f] || m_hall(f, m_dir) || !m_beyond(f, m_dir)) begin
          do_serve = 1;
          do_flip  = !m_beyond(f, m_dir);
        end
      end
    end else begin
      suppress = 1;
      if (i_door_hold || n_car[f] || n_up[f] || n_dn[f]) m_door_left = DT;
      else begin
        m_door_left--;
        if (m_door_left == 0) m_mode = 0;
      end
    end
    for (int i = 0; i < N; i++)
      if (!(suppress && i == m_floor)) begin
        m_car[i] |= n_car[i]; m_up[i] |= n_up[i]; m_dn[i] |= n_dn[i];
      end
    if (do_serve) begin
      m_car[f] = 0;
      if (do_flip || m_dir >= 0) m_up[f] = 0;
      if (do_flip || m_dir <= 0) m_dn[f] = 0;
      if (do_flip) m_dir = -m_dir;
      m_mode = 2;
      m_door_left = DT;
    end
    if (i_stop) begin
      m_halted = 1;
      m_door_frozen = door_before;
    end
  endtask

  task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_model();
    check_output("floor",   32'(o_current_floor), 32'(m_floor));
    check_output("up",      32'(o_up),     32'(!m_halted && m_mode == 1 && m_dir > 0));
    check_output("down",    32'(o_down),   32'(!m_halted && m_mode == 1 && m_dir < 0));
    check_output("door",    32'(o_door),   32'(m_door_out()));
    check_output("pending", 32'(o_pending), 32'(m_pending()));
    check_output("halted",  32'(o_halted), 32'(m_halted));
  endtask

  task automatic step();
    @(posedge i_clk);
    model_tick();
    #1;
    check_model();
    if (o_door && !prev_door) door_floors.push_back(int'(o_current_floor));
    prev_door = o_door;
  endtask

  task automatic apply_stimulus(input logic [N-1:0] car, input logic [N-1:0] up, input logic [N-1:0] dn,
                                input logic stop, input logic hold);
    i_car_req = car; i_hall_up = up; i_hall_dn = dn; i_stop = stop; i_door_hold = hold;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) apply_stimulus('0, '0, '0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    i_car_req = '0; i_hall_up = '0; i_hall_dn = '0; i_stop = 0; i_door_hold = 0;
    i_rst_n = 1'b0;
    model_reset();
    #2;
    check_output("rst_floor",   32'(o_current_floor), 32'd0);
    check_output("rst_motor",   32'({o_up, o_down}), 32'd0);
    check_output("rst_door",    32'(o_door), 32'd0);
    check_output("rst_pending", 32'(o_pending), 32'd0);
    check_output("rst_halted",  32'(o_halted), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    prev_door = 1'b0;
    door_floors.delete();
  endtask

  task automatic check_doors(input string tag, input int a, input int b);
    check_output({tag, "_count"}, 32'(door_floors.size()), 32'd2);
    check_output({tag, "_first"},  32'(door_floors.size() > 0 ? door_floors[0] : -1), 32'(a));
    check_output({tag, "_second"}, 32'(door_floors.size() > 1 ? door_floors[1] : -1), 32'(b));
  endtask

  initial begin
    bit pulsed;
    logic [N-1:0] rc, ru, rd;

    do_reset();
    apply_stimulus(8'h08, '0, '0, 0, 0);
    check_output("t1_pending", 32'(o_pending), 32'h08);
    idle(1);
    check_output("t1_up_start", 32'(o_up), 32'd1);
    for (int k = 3; k <= 42; k++) begin
      idle(1);
      if (k == 12) check_output("t1_floor1", 32'(o_current_floor), 32'd1);
      if (k == 22) check_output("t1_floor2", 32'(o_current_floor), 32'd2);
      if (k == 32) begin
        check_output("t1_floor3", 32'(o_current_floor), 32'd3);
        check_output("t1_door_rise", 32'({o_door, o_up}), 32'b10);
        check_output("t1_served", 32'(o_pending), 32'd0);
      end
      if (k == 41) check_output("t1_door_last", 32'(o_door), 32'd1);
      if (k == 42) check_output("t1_door_close", 32'(o_door), 32'd0);
    end

    do_reset();
    apply_stimulus(8'h20, '0, 8'h04, 0, 0);
    idle(200);
    check_doors("t2_doors", 5, 2);

    do_reset();
    apply_stimulus('0, 8'h10, '0, 0, 0);
    pulsed = 0;
    for (int k = 0; k < 200; k++) begin
      if (!pulsed && o_current_floor == 3'd1) begin
        apply_stimulus('0, '0, 8'h08, 0, 0);
        pulsed = 1;
      end else idle(1);
    end
    check_output("t3_pulsed", 32'(pulsed), 32'd1);
    check_doors("t3_doors", 4, 3);

    do_reset();
    apply_stimulus(8'h04, '0, '0, 0, 0);
    idle(1);
    check_output("t4_move", 32'(o_up), 32'd1);
    idle(4);
    apply_stimulus('0, '0, '0, 1, 0);
    check_output("t4_halt_motor", 32'(o_up), 32'd0);
    check_output("t4_halted", 32'(o_halted), 32'd1);
    idle(49);
    apply_stimulus('0, '0, '0, 1, 0);
    check_output("t4_resume", 32'({o_halted, o_up}), 32'b01);
    idle(4);
    check_output("t4_still_floor0", 32'(o_current_floor), 32'd0);
    idle(1);
    check_output("t4_floor1", 32'(o_current_floor), 32'd1);

    do_reset();
    apply_stimulus(8'h01, '0, '0, 0, 0);
    idle(1);
    check_output("t5_door_open", 32'(o_door), 32'd1);
    idle(2);
    for (int k = 0; k < 25; k++) apply_stimulus('0, '0, '0, 0, 1);
    idle(9);
    check_output("t5_hold_tail", 32'(o_door), 32'd1);
    idle(1);
    check_output("t5_hold_close", 32'(o_door), 32'd0);
    do_reset();
    apply_stimulus(8'h01, '0, '0, 0, 0);
    idle(4);
    apply_stimulus(8'h01, '0, '0, 0, 0);
    check_output("t5_req_not_latched", 32'(o_pending), 32'd0);
    idle(9);
    check_output("t5_restart_tail", 32'(o_door), 32'd1);
    idle(1);
    check_output("t5_restart_close", 32'(o_door), 32'd0);

    do_reset();
    apply_stimulus(8'h20, '0, '0, 0, 0);
    for (int k = 0; k < 100 && o_current_floor != 3'd2; k++) idle(1);
    check_output("t6_at_floor2", 32'(o_current_floor), 32'd2);
    idle(3);
    do_reset();
    apply_stimulus('0, 8'h80, 8'h01, 0, 0);
    check_output("t6_ignored_bits", 32'(o_pending), 32'd0);
    idle(2);
    check_output("t6_still_idle", 32'({o_pending, o_up, o_down, o_door}), 32'd0);

    do_reset();
    for (int k = 0; k < 4000; k++) begin
      rc = ($urandom_range(0, 9) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
      ru = ($urandom_range(0, 11) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
      rd = ($urandom_range(0, 11) == 0) ? N'(1) << $urandom_range(0, N - 1) : '0;
      apply_stimulus(rc, ru, rd, $urandom_range(0, 149) == 0, $urandom_range(0, 39) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
